// File: rtl/nn_run_ctrl.sv
// nn_run_ctrl
// Sequences one classifier run per received UART frame. Start/train pulses
// from the frame parser launch the compute engine with a latched mode. The
// block then waits for completion or a timeout and returns a two-byte
// response (header, payload) over a byte-wide ready/valid TX interface.
// Start pulses that arrive while a run is in progress are dropped and
// reported through the sticky overrun flag.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   train, start      one-cycle pulses from the frame parser
//   nn_done, nn_label engine completion and result (sampled only while waiting)
//   nn_go, nn_train   launch pulse and run mode to the engine
//   tx_data, tx_valid response byte stream
//   tx_ready          TX sink accepts a byte when tx_valid && tx_ready
//   clr_err           synchronous clear of the sticky flags
//   busy              a run is in progress
//   overrun           sticky: a start pulse was dropped while busy
//   timeout_err       sticky: a run was aborted on timeout
module nn_run_ctrl #(
    parameter logic [23:0] TIMEOUT  = 24'd50000,
    parameter logic [7:0]  RESP_HDR = 8'hFF,
    parameter logic [7:0]  ACK_BYTE = 8'hAA,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       train,
    input  logic       start,
    input  logic       nn_done,
    input  logic [3:0] nn_label,
    output logic       nn_go,
    output logic       nn_train,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       clr_err,
    output logic       busy,
    output logic       overrun,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_HDR    = 3'd3,
        S_PAY    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_TRAIN = 2'd0,
        RES_TEST  = 2'd1,
        RES_ERR   = 2'd2
    } result_t;

    // Last counter value allowed in S_WAIT before the run is aborted.
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT - 24'd1;

    state_t      state_q, state_d;
    result_t     result_q, result_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  label_q, label_d;
    logic        pend_train_q, pend_train_d;
    logic        nn_go_q, nn_go_d;
    logic        nn_train_q, nn_train_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;
    logic        timeout_hit_s;

    // Payload byte for a finished run.
    function automatic logic [7:0] payload_byte(input result_t res, input logic [3:0] lbl);
        logic [7:0] b;
        case (res)
            RES_TRAIN: b = ACK_BYTE;
            RES_TEST:  b = {4'h0, lbl};
            RES_ERR:   b = ERR_BYTE;
            default:   b = ERR_BYTE;
        endcase
        return b;
    endfunction

    // Next-state logic; outputs are precomputed from the next state so
    // that every output leaves a flop.
    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        cnt_d         = cnt_q;
        label_d       = label_q;
        nn_train_d    = nn_train_q;
        timeout_hit_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LAUNCH;
                    // A train pulse in the same cycle as start still counts.
                    nn_train_d = pend_train_q | train;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                cnt_d   = 24'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 24'd1;
                // Completion takes priority over a coinciding timeout.
                if (nn_done) begin
                    label_d  = nn_label;
                    result_d = nn_train_q ? RES_TRAIN : RES_TEST;
                    state_d  = S_HDR;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    result_d      = RES_ERR;
                    timeout_hit_s = 1'b1;
                    state_d       = S_HDR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HDR: begin
                if (tx_ready) begin
                    state_d = S_PAY;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_PAY: begin
                if (tx_ready) begin
                    state_d    = S_IDLE;
                    nn_train_d = 1'b0;
                end else begin
                    state_d = S_PAY;
                end
            end
            default: begin
                state_d    = S_IDLE;
                nn_train_d = 1'b0;
            end
        endcase

        nn_go_d    = (state_d == S_LAUNCH);
        busy_d     = (state_d != S_IDLE);
        tx_valid_d = (state_d == S_HDR) || (state_d == S_PAY);

        case (state_d)
            S_HDR:   tx_data_d = RESP_HDR;
            S_PAY:   tx_data_d = payload_byte(result_d, label_d);
            default: tx_data_d = 8'h00;
        endcase

        // A start, whether consumed or dropped, always clears the pending mode.
        if (start) begin
            pend_train_d = 1'b0;
        end else if (train) begin
            pend_train_d = 1'b1;
        end else begin
            pend_train_d = pend_train_q;
        end

        // Sticky flags: a set event wins over a simultaneous clear.
        if (start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (timeout_hit_s) begin
            timeout_err_d = 1'b1;
        end else if (clr_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            result_q      <= RES_TRAIN;
            cnt_q         <= 24'd0;
            label_q       <= 4'd0;
            pend_train_q  <= 1'b0;
            nn_go_q       <= 1'b0;
            nn_train_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            cnt_q         <= cnt_d;
            label_q       <= label_d;
            pend_train_q  <= pend_train_d;
            nn_go_q       <= nn_go_d;
            nn_train_q    <= nn_train_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign nn_go       = nn_go_q;
    assign nn_train    = nn_train_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/nn_run_ctrl.md
Name: nn_run_ctrl

Overview:
Sequences one classifier run per received UART frame. Consumes the one-cycle train/start pulses from the UART frame parser and launches the compute engine with a latched mode. It waits for completion or a timeout, then returns a two-byte response frame through a byte-wide ready/valid TX interface. It also buffers the parser's pulses and reports frames dropped while busy.

Parameters:
TIMEOUT, 24'd50000, max cycles spent in S_WAIT before abort (legal range 2..2^24-1)
RESP_HDR, 8'hFF, first byte of every response frame
ACK_BYTE, 8'hAA, payload byte for a completed train run
ERR_BYTE, 8'hEE, payload byte for a timed-out run

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
train  in  1  one-cycle pulse from frame parser: current frame is a train frame
start  in  1  one-cycle pulse from frame parser: frame complete, image valid
nn_done  in  1  engine completion, one-cycle pulse or level; sampled only in S_WAIT
nn_label  in  4  engine result, valid in the cycle nn_done is sampled
nn_go  out  1  one-cycle launch pulse to engine
nn_train  out  1  run mode to engine (1 = train), stable from S_LAUNCH through S_WAIT
tx_data  out  8  response byte
tx_valid  out  1  response byte valid
tx_ready  in  1  UART TX accepts byte when tx_valid && tx_ready
clr_err  in  1  synchronous clear of sticky flags
busy  out  1  state != S_IDLE
overrun  out  1  sticky: start pulse dropped while busy
timeout_err  out  1  sticky: a run aborted on timeout

Behaviour:
- Reset (async): state S_IDLE; all outputs 0; pend_train=0, timeout counter=0, label reg=0.
- pend_train: set by train in any state. Cleared when a start is consumed in S_IDLE, and when a start is dropped.
- train and start in the same cycle: pend_train counts as 1 for that start.
- States:
  - S_IDLE: on start -> S_LAUNCH; latch nn_train <= pend_train | train.
  - S_LAUNCH: nn_go=1 for exactly this cycle; counter <= 0; -> S_WAIT.
  - S_WAIT: counter increments each cycle. When nn_done=1, capture nn_label, set result=train/test -> S_HDR. Otherwise, when counter == TIMEOUT-1, set timeout_err=1, result=error -> S_HDR. If nn_done and the timeout coincide, nn_done wins.
  - S_HDR: tx_valid=1, tx_data=RESP_HDR; on handshake -> S_PAY.
  - S_PAY: tx_valid=1. tx_data = ACK_BYTE (train), {4'h0,label} (test) or ERR_BYTE (error). On handshake -> S_IDLE; nn_train <= 0.
- Latency:
  - start at cycle N -> nn_go at N+1, S_WAIT at N+2.
  - nn_done at M -> tx_valid at M+1.
  - With tx_ready held at 1: header at M+1, payload at M+2, busy=0 at M+3.
- TX rules:
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid never drops without a handshake.
  - Stall is unbounded; no timeout applies in TX states.
- start in any state other than S_IDLE: ignored, overrun <= 1, pend_train <= 0.
- nn_done outside S_WAIT is ignored, including a pulse in the S_LAUNCH cycle.
- clr_err clears overrun/timeout_err. A set event in the same cycle wins.
- rst mid-run: immediate return to S_IDLE; any partial frame is abandoned and nn_go is not reissued.

Test Plan:
- Test frame: start=1 at cycle 10, tx_ready=1, nn_done at 20 with label=7 -> nn_go=1 at 11 only, nn_train=0; tx bytes FF then 07 at 21/22; busy=0 at 23.
- Train frame: train at 5, start at 10, nn_done at 15 -> nn_train=1 during cycles 11-15; response FF, AA; next test frame shows nn_train=0.
- Timeout with TIMEOUT=8, nn_done never asserted -> S_WAIT lasts 8 cycles; response FF, EE; timeout_err=1 until clr_err. Repeat with nn_done on the final cycle -> normal label response, timeout_err stays 0.
- Backpressure: tx_ready=0 for 6 cycles in S_HDR -> tx_valid=1, tx_data=FF held constant; exactly 2 handshakes total.
- Overrun: second train+start during S_WAIT -> overrun=1, no second nn_go; following start in idle runs as test (pend_train cleared).
- Async rst asserted in S_WAIT -> all outputs 0 immediately; a new start afterwards completes a normal run.
